// File: rtl/risc_register_file.sv
// -----------------------------------------------------------------------------
// risc_register_file
//
// Architectural integer register file for the RISC-V core. Two independent
// read ports (A = rs1, B = rs2) answer operand-fetch requests from the
// instruction handler, and one write port accepts ALU write-back. Every
// response is a registered, unconditional one-cycle reply: the block never
// stalls its requesters.
//
// Ports:
//   clk                  - system clock, all state updates on posedge
//   reset                - asynchronous, active-high reset
//   reg_rd_addr_a        - port A read index (rs1)
//   reg_rd_addr_a_valid  - port A request valid (level-sensitive)
//   reg_rd_data_a        - port A read data (registered)
//   reg_rd_data_a_ack    - port A data valid
//   reg_rd_addr_b        - port B read index (rs2)
//   reg_rd_addr_b_valid  - port B request valid (level-sensitive)
//   reg_rd_data_b        - port B read data (registered)
//   reg_rd_data_b_ack    - port B data valid
//   reg_wr_addr          - write-back index (rd)
//   reg_wr_data          - write-back data
//   reg_wr_valid         - write request
//   reg_wr_ack           - write accepted, one pulse per accepted write
//   wr_done              - write-back complete, routed to the handler's done
// -----------------------------------------------------------------------------
module risc_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_a,
    input  logic                  reg_rd_addr_a_valid,
    output logic [DATA_WIDTH-1:0] reg_rd_data_a,
    output logic                  reg_rd_data_a_ack,

    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_b,
    input  logic                  reg_rd_addr_b_valid,
    output logic [DATA_WIDTH-1:0] reg_rd_data_b,
    output logic                  reg_rd_data_b_ack,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_wr_valid,
    output logic                  reg_wr_ack,
    output logic                  wr_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage and registered outputs
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [DATA_WIDTH-1:0] rdDataA_q, rdDataA_d;
    logic                  rdAckA_q,  rdAckA_d;
    logic [DATA_WIDTH-1:0] rdDataB_q, rdDataB_d;
    logic                  rdAckB_q,  rdAckB_d;
    logic                  wrAck_q,   wrAck_d;
    logic                  wrDone_q,  wrDone_d;

    // Decoded write qualifiers
    logic wrToZero;
    logic wrEnable;

    // Index 0 is only special when the hardwired-zero register is enabled.
    function automatic logic isZeroIndex(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Value a read port captures this cycle. A concurrent write to the same
    // index is forwarded so the reader never sees the stale entry; the zero
    // register is checked first so a discarded write to x0 is never forwarded.
    function automatic logic [DATA_WIDTH-1:0] readLookup(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wrValid,
        input logic [ADDR_WIDTH-1:0] wrAddr,
        input logic [DATA_WIDTH-1:0] wrData,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] value;
        value = stored;
        if (isZeroIndex(addr)) begin
            value = '0;
        end else if (wrValid && (wrAddr == addr)) begin
            value = wrData;
        end
        return value;
    endfunction

    // Writes to the hardwired zero register are still acknowledged but must
    // leave storage untouched.
    always_comb begin
        wrToZero = isZeroIndex(reg_wr_addr);
        wrEnable = reg_wr_valid && !wrToZero;
    end

    // Next-state storage: at most one entry changes per cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wrEnable) begin
            mem_d[reg_wr_addr] = reg_wr_data;
        end
    end

    // Port A: data only moves on a valid request; otherwise it holds so the
    // handler can keep reading the last operand after ack drops.
    always_comb begin
        rdDataA_d = rdDataA_q;
        rdAckA_d  = reg_rd_addr_a_valid;
        if (reg_rd_addr_a_valid) begin
            rdDataA_d = readLookup(reg_rd_addr_a, reg_wr_valid, reg_wr_addr,
                                   reg_wr_data, mem_q[reg_rd_addr_a]);
        end
    end

    // Port B: identical to port A and fully independent of it.
    always_comb begin
        rdDataB_d = rdDataB_q;
        rdAckB_d  = reg_rd_addr_b_valid;
        if (reg_rd_addr_b_valid) begin
            rdDataB_d = readLookup(reg_rd_addr_b, reg_wr_valid, reg_wr_addr,
                                   reg_wr_data, mem_q[reg_rd_addr_b]);
        end
    end

    // Write handshake: every sampled request is acknowledged, including the
    // discarded x0 writes, so the handler always gets its done pulse.
    always_comb begin
        wrAck_d  = reg_wr_valid;
        wrDone_d = reg_wr_valid;
    end

    // State registers. Reset is asynchronous so outputs drop the moment it
    // asserts and any request sampled before the next edge is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdDataA_q <= '0;
            rdAckA_q  <= 1'b0;
            rdDataB_q <= '0;
            rdAckB_q  <= 1'b0;
            wrAck_q   <= 1'b0;
            wrDone_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdDataA_q <= rdDataA_d;
            rdAckA_q  <= rdAckA_d;
            rdDataB_q <= rdDataB_d;
            rdAckB_q  <= rdAckB_d;
            wrAck_q   <= wrAck_d;
            wrDone_q  <= wrDone_d;
        end
    end

    // All outputs come straight from flops.
    assign reg_rd_data_a     = rdDataA_q;
    assign reg_rd_data_a_ack = rdAckA_q;
    assign reg_rd_data_b     = rdDataB_q;
    assign reg_rd_data_b_ack = rdAckB_q;
    assign reg_wr_ack        = wrAck_q;
    assign wr_done           = wrDone_q;

endmodule

// File: tb/tb_risc_register_file.sv
// -----------------------------------------------------------------------------
// tb_risc_register_file
//
// Self-checking bench for risc_register_file. A table of directed vectors and
// a modelled random phase push expected outputs to a scoreboard queue as
// stimulus is driven; entries are popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_risc_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rdAddrA;
    logic          rdValidA;
    logic [DW-1:0] rdDataA;
    logic          rdAckA;
    logic [AW-1:0] rdAddrB;
    logic          rdValidB;
    logic [DW-1:0] rdDataB;
    logic          rdAckB;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          wrValid;
    logic          wrAck;
    logic          wrDone;

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          av;
        logic [AW-1:0] aa;
        logic          bv;
        logic [AW-1:0] ba;
        logic          expAckA;
        logic [DW-1:0] expA;
        logic          expAckB;
        logic [DW-1:0] expB;
        logic          expWr;
    } vec_t;

    vec_t vecTable[17];
    vec_t scoreboard[$];

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] memModel[32];
    logic [DW-1:0] prevA;
    logic [DW-1:0] prevB;

    risc_register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .reg_rd_addr_a      (rdAddrA),
        .reg_rd_addr_a_valid(rdValidA),
        .reg_rd_data_a      (rdDataA),
        .reg_rd_data_a_ack  (rdAckA),
        .reg_rd_addr_b      (rdAddrB),
        .reg_rd_addr_b_valid(rdValidB),
        .reg_rd_data_b      (rdDataB),
        .reg_rd_data_b_ack  (rdAckB),
        .reg_wr_addr        (wrAddr),
        .reg_wr_data        (wrData),
        .reg_wr_valid       (wrValid),
        .reg_wr_ack         (wrAck),
        .wr_done            (wrDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic av, input logic [AW-1:0] aa,
        input logic bv, input logic [AW-1:0] ba,
        input logic eka, input logic [DW-1:0] ea,
        input logic ekb, input logic [DW-1:0] eb,
        input logic ew
    );
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd;
        v.av = av; v.aa = aa; v.bv = bv; v.ba = ba;
        v.expAckA = eka; v.expA = ea;
        v.expAckB = ekb; v.expB = eb;
        v.expWr = ew;
        return v;
    endfunction

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare the
    // outputs produced by the next edge against the popped entry.
    task automatic applyStimulus(input vec_t v);
        vec_t e;
        wrValid  = v.wv; wrAddr  = v.wa; wrData = v.wd;
        rdValidA = v.av; rdAddrA = v.aa;
        rdValidB = v.bv; rdAddrB = v.ba;
        scoreboard.push_back(v);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = scoreboard.pop_front();
            checkOutput("ackA",   {31'd0, rdAckA}, {31'd0, e.expAckA});
            checkOutput("dataA",  rdDataA,         e.expA);
            checkOutput("ackB",   {31'd0, rdAckB}, {31'd0, e.expAckB});
            checkOutput("dataB",  rdDataB,         e.expB);
            checkOutput("wrAck",  {31'd0, wrAck},  {31'd0, e.expWr});
            checkOutput("wrDone", {31'd0, wrDone}, {31'd0, e.expWr});
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ackA"},   {31'd0, rdAckA}, '0);
        checkOutput({tag, "_dataA"},  rdDataA,         '0);
        checkOutput({tag, "_ackB"},   {31'd0, rdAckB}, '0);
        checkOutput({tag, "_dataB"},  rdDataB,         '0);
        checkOutput({tag, "_wrAck"},  {31'd0, wrAck},  '0);
        checkOutput({tag, "_wrDone"}, {31'd0, wrDone}, '0);
    endtask

    task automatic idleInputs();
        wrValid = 1'b0; wrAddr = '0; wrData = '0;
        rdValidA = 1'b0; rdAddrA = '0;
        rdValidB = 1'b0; rdAddrB = '0;
    endtask

    initial begin
        //                  wv wa  wd            av aa  bv ba  kA A             kB B             wr
        vecTable[0]  = mk(0, 0,  32'h0,        1, 5,  1, 31, 1, 32'h0,        1, 32'h0,        0);
        vecTable[1]  = mk(1, 7,  32'hDEADBEEF, 0, 0,  0, 0,  0, 32'h0,        0, 32'h0,        1);
        vecTable[2]  = mk(0, 0,  32'h0,        1, 7,  1, 7,  1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
        vecTable[3]  = mk(1, 0,  32'h12345678, 0, 0,  0, 0,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1);
        vecTable[4]  = mk(0, 0,  32'h0,        1, 0,  0, 0,  1, 32'h0,        0, 32'hDEADBEEF, 0);
        vecTable[5]  = mk(1, 4,  32'h11,       0, 0,  0, 0,  0, 32'h0,        0, 32'hDEADBEEF, 1);
        vecTable[6]  = mk(1, 3,  32'hA5A5A5A5, 1, 3,  1, 4,  1, 32'hA5A5A5A5, 1, 32'h11,       1);
        vecTable[7]  = mk(0, 0,  32'h0,        1, 3,  1, 3,  1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 0);
        vecTable[8]  = mk(1, 1,  32'h10,       0, 0,  0, 0,  0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1);
        vecTable[9]  = mk(1, 2,  32'h20,       0, 0,  0, 0,  0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1);
        vecTable[10] = mk(1, 3,  32'h30,       0, 0,  0, 0,  0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1);
        vecTable[11] = mk(0, 0,  32'h0,        1, 1,  0, 0,  1, 32'h10,       0, 32'hA5A5A5A5, 0);
        vecTable[12] = mk(0, 0,  32'h0,        1, 2,  0, 0,  1, 32'h20,       0, 32'hA5A5A5A5, 0);
        vecTable[13] = mk(0, 0,  32'h0,        1, 3,  0, 0,  1, 32'h30,       0, 32'hA5A5A5A5, 0);
        vecTable[14] = mk(1, 0,  32'hFFFFFFFF, 1, 0,  1, 0,  1, 32'h0,        1, 32'h0,        1);
        vecTable[15] = mk(1, 31, 32'hCAFEF00D, 1, 31, 1, 31, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1);
        vecTable[16] = mk(0, 0,  32'h0,        0, 0,  0, 0,  0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);

        // Reset asserted from time zero; outputs must already be cleared.
        reset = 1'b1;
        idleInputs();
        wrValid = 1'b1;
        wrAddr  = 5'd2;
        wrData  = 32'h99;
        #1;
        checkAllZero("rstInit");
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("rstHeld");
        idleInputs();
        reset = 1'b0;

        foreach (vecTable[i]) begin
            applyStimulus(vecTable[i]);
        end

        // Load x9, then abort a second write to it with an async reset that
        // lands between clock edges.
        applyStimulus(mk(1, 9, 32'h55, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1));
        wrValid = 1'b1; wrAddr = 5'd9; wrData = 32'h77;
        rdValidA = 1'b1; rdAddrA = 5'd9;
        #3;
        reset = 1'b1;
        #1;
        checkAllZero("asyncRst");
        @(posedge clk);
        #2;
        idleInputs();
        reset = 1'b0;
        applyStimulus(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        applyStimulus(mk(0, 0, 32'h0, 1, 9, 1, 9, 1, 32'h0, 1, 32'h0, 0));

        // Random phase against a behavioural model; small index range to
        // make collisions and x0 accesses frequent.
        for (int i = 0; i < 32; i++) memModel[i] = '0;
        prevA = '0;
        prevB = '0;
        for (int n = 0; n < 80; n++) begin
            vec_t v;
            v.wv = 1'($urandom_range(0, 1));
            v.wa = 5'($urandom_range(0, 7));
            v.wd = $urandom;
            v.av = 1'($urandom_range(0, 1));
            v.aa = 5'($urandom_range(0, 7));
            v.bv = 1'($urandom_range(0, 1));
            v.ba = 5'($urandom_range(0, 7));
            v.expAckA = v.av;
            v.expAckB = v.bv;
            v.expWr   = v.wv;
            if (v.av) begin
                if (v.aa == 0)                   prevA = '0;
                else if (v.wv && v.wa == v.aa)   prevA = v.wd;
                else                             prevA = memModel[v.aa];
            end
            if (v.bv) begin
                if (v.ba == 0)                   prevB = '0;
                else if (v.wv && v.wa == v.ba)   prevB = v.wd;
                else                             prevB = memModel[v.ba];
            end
            v.expA = prevA;
            v.expB = prevB;
            if (v.wv && v.wa != 0) memModel[v.wa] = v.wd;
            applyStimulus(v);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/risc_register_file.md
Name: risc_register_file

Overview:
- Architectural 32-entry integer register file for the RISC-V core.
- Sits directly downstream of the instruction handler's operand-fetch requests. It serves two independent read ports, A (rs1) and B (rs2), using valid/ack handshakes.
- Accepts ALU write-back through a single write port with valid/ack handshake.
- Emits `wr_done`, which the top level routes to the handler's `done` input to close each instruction.

Parameters:
- `DATA_WIDTH`, 32, width of each register and data port.
- `ADDR_WIDTH`, 5, register index width; depth = 2**`ADDR_WIDTH`.
- `ZERO_REG`, 1, when 1, index 0 is hardwired to zero and writes to it are discarded.

Ports:
- `clk`  input  1  system clock; all state updates on posedge.
- `reset`  input  1  asynchronous, active-high reset.
- `reg_rd_addr_a`  input  `ADDR_WIDTH`  port A read index (rs1).
- `reg_rd_addr_a_valid`  input  1  port A request valid, level-sensitive.
- `reg_rd_data_a`  output  `DATA_WIDTH`  port A read data, registered.
- `reg_rd_data_a_ack`  output  1  port A data valid.
- `reg_rd_addr_b`  input  `ADDR_WIDTH`  port B read index (rs2).
- `reg_rd_addr_b_valid`  input  1  port B request valid.
- `reg_rd_data_b`  output  `DATA_WIDTH`  port B read data, registered.
- `reg_rd_data_b_ack`  output  1  port B data valid.
- `reg_wr_addr`  input  `ADDR_WIDTH`  write-back index (rd).
- `reg_wr_data`  input  `DATA_WIDTH`  write-back data.
- `reg_wr_valid`  input  1  write request.
- `reg_wr_ack`  output  1  write accepted, 1-cycle pulse.
- `wr_done`  output  1  write-back complete, 1-cycle pulse to handler `done`.

Behaviour:
- Reset (async, active-high, asserted anytime):
  - All entries clear to 0.
  - `reg_rd_data_a`/`reg_rd_data_b` = 0.
  - All acks and `wr_done` = 0.
  - Any in-flight read or write is dropped with no ack.
  - On deassertion, the first request is sampled at the next posedge.
- Read ports (A and B identical and fully independent):
  - At each posedge with valid=1, `data <= mem[addr]` and `ack <= 1`.
  - At a posedge with valid=0, `ack <= 0` and data holds its last value.
  - Latency is one cycle from valid/addr sampled to ack/data.
  - While valid is held high, data tracks addr every cycle and ack stays high. The handler may sample on any cycle with ack=1.
  - Address 0 with `ZERO_REG`=1 always returns 0.
- Write port:
  - At a posedge with `reg_wr_valid`=1, `mem[reg_wr_addr] <= reg_wr_data`, `reg_wr_ack <= 1` and `wr_done <= 1`. Otherwise both are driven 0 next cycle.
  - `reg_wr_valid` held high N cycles performs N writes, one per cycle, with N ack pulses (ack stays high).
  - A write to index 0 with `ZERO_REG`=1 is discarded but still acked and still pulses `wr_done`.
- Read/write collision (same posedge, write valid, read valid, same non-zero index):
  - Read returns `reg_wr_data` (write-first bypass), never the stale value.
  - Applies to both ports simultaneously; A and B may read the same index.
- No stalls: the block never back-pressures; acks are unconditional one-cycle responses.
- Storage holds `2**ADDR_WIDTH` x `DATA_WIDTH` flops. No reset-to-X values; no read-modify-write.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Assert reset, release, then read A=5, B=31 → one cycle later both acks=1 and both data=0. Check `reg_wr_ack`=`wr_done`=0 throughout reset.
- Write x7=0xDEADBEEF (one cycle valid), then read A=7, B=7 → `reg_wr_ack`=`wr_done`=1 for exactly one cycle after the write. Next read returns 0xDEADBEEF on both ports with 1-cycle latency.
- Write x0=0x12345678, then read A=0 → ack pulses, and A data=0.
- Same cycle: write x3=0xA5A5A5A5, read A=3, B=4 (x4 previously 0x11) → next cycle A=0xA5A5A5A5 (bypass) and B=0x00000011.
- Hold read valid A high while stepping addr 1,2,3 (preloaded 0x10,0x20,0x30) → ack stays 1 and data follows 0x10, 0x20, 0x30 one cycle behind. Hold `reg_wr_valid` for 3 cycles → 3 consecutive ack cycles and 3 writes.
- Assert reset asynchronously mid-cycle while write valid is high and x9 was 0x55 → outputs drop immediately without waiting for a clock. After release, reading x9 returns 0 and no `wr_done` is emitted for the aborted write.
